// File: rtl/reg_file_2r1w.sv
`default_nettype none
// ============================================================================
// reg_file_2r1w : two-read / one-write register file, optional zero register
//                 and same-cycle write-to-read forwarding.
// Revision 1.0
// ============================================================================
module reg_file_2r1w #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  output logic [WIDTH-1:0]  za,
  output logic [WIDTH-1:0]  zb
);

  logic [WIDTH-1:0] w_rd [DEPTH];
  logic [WIDTH-1:0] w_a_sel;
  logic [WIDTH-1:0] w_b_sel;
  logic             w_fwd;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
        // Hard-wired zero: no storage, writes to address 0 simply vanish.
        assign w_rd[gi] = '0;
      end else begin : g_store
        logic [WIDTH-1:0] r_q;
        always_ff @(posedge clk) begin
          if (!reset_n)
            r_q <= '0;
          else if (we && (wa == ADDR_W'(gi)))
            r_q <= wd;
        end
        assign w_rd[gi] = r_q;
      end
    end
  endgenerate

  always_comb begin
    w_a_sel = '0;
    w_b_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ra == ADDR_W'(i)) w_a_sel = w_rd[i];
      if (rb == ADDR_W'(i)) w_b_sel = w_rd[i];
    end
  end

  // Forwarding only for a write that will actually land in storage.
  assign w_fwd = (BYPASS != 0) && reset_n && we &&
                 !((ZERO_REG != 0) && (wa == '0));

  assign za = (w_fwd && (ra == wa)) ? wd : w_a_sel;
  assign zb = (w_fwd && (rb == wa)) ? wd : w_b_sel;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_2r1w.sv
`default_nettype none
// ============================================================================
// tb_reg_file_2r1w : scoreboard bench for reg_file_2r1w (bypass, no-bypass
//                    and 8x8 instances).
// Revision 1.0
// ============================================================================
module tb_reg_file_2r1w;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        we;
  logic [4:0]  wa, ra, rb;
  logic [31:0] wd;
  logic [31:0] za, zb, nb_za, nb_zb;

  logic        s_we;
  logic [2:0]  s_wa, s_ra, s_rb;
  logic [7:0]  s_wd, s_za, s_zb;

  always #5 clk = ~clk;

  reg_file_2r1w u_dut (
    .clk(clk), .reset_n(reset_n), .we(we), .wa(wa), .wd(wd),
    .ra(ra), .rb(rb), .za(za), .zb(zb)
  );

  reg_file_2r1w #(.BYPASS(0)) u_nb (
    .clk(clk), .reset_n(reset_n), .we(we), .wa(wa), .wd(wd),
    .ra(ra), .rb(rb), .za(nb_za), .zb(nb_zb)
  );

  reg_file_2r1w #(.WIDTH(8), .DEPTH(8), .ADDR_W(3)) u_small (
    .clk(clk), .reset_n(reset_n), .we(s_we), .wa(s_wa), .wd(s_wd),
    .ra(s_ra), .rb(s_rb), .za(s_za), .zb(s_zb)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   tests_run = 0;
  int   failed    = 0;

  localparam int P_ZA = 0, P_ZB = 1, P_NA = 2, P_NB = 3, P_SA = 4, P_SB = 5;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      P_ZA:    return za;
      P_ZB:    return zb;
      P_NA:    return nb_za;
      P_NB:    return nb_zb;
      P_SA:    return {24'h0, s_za};
      default: return {24'h0, s_zb};
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    q.push_back(e);
  endtask

  // Compare everything queued for this cycle, then advance past the next edge.
  task automatic step();
    exp_t        e;
    logic [31:0] obs;
    @(negedge clk);
    while (q.size() > 0) begin
      e   = q.pop_front();
      obs = observe(e.sel);
      tests_run++;
      assert (obs === e.exp) else begin
        failed++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra = '0; rb = '0;
    s_we = 1'b0; s_wa = '0; s_wd = '0; s_ra = '0; s_rb = '0;
    repeat (2) @(posedge clk);
    #1;

    reset_n = 1'b1; ra = 5'h03; rb = 5'h1F; s_ra = 3'd3; s_rb = 3'd7;
    push("rst_za", P_ZA, 32'h0);
    push("rst_zb", P_ZB, 32'h0);
    push("rst_nb_za", P_NA, 32'h0);
    push("rst_s_za", P_SA, 32'h0);
    push("rst_s_zb", P_SB, 32'h0);
    step();

    // Write i to register i; same-address reads see bypass vs. old value.
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wa = 5'(i); wd = 32'(i); ra = 5'(i); rb = 5'(i);
      push($sformatf("byp_za_%0d", i), P_ZA, 32'(i));
      push($sformatf("byp_zb_%0d", i), P_ZB, 32'(i));
      push($sformatf("nobyp_za_%0d", i), P_NA, 32'h0);
      step();
    end

    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra = 5'(i); rb = 5'(31 - i);
      push($sformatf("sweep_za_%0d", i), P_ZA, 32'(i));
      push($sformatf("sweep_zb_%0d", i), P_ZB, 32'(31 - i));
      push($sformatf("sweep_nb_za_%0d", i), P_NA, 32'(i));
      step();
    end

    we = 1'b1; wa = 5'h00; wd = 32'hDEAD_BEEF; ra = 5'h00; rb = 5'h00;
    push("zero_wr_za", P_ZA, 32'h0);
    push("zero_wr_zb", P_ZB, 32'h0);
    push("zero_wr_nb", P_NA, 32'h0);
    step();
    we = 1'b0;
    push("zero_after_za", P_ZA, 32'h0);
    push("zero_after_nb", P_NA, 32'h0);
    step();

    we = 1'b1; wa = 5'h07; wd = 32'hA5A5_A5A5; ra = 5'h07; rb = 5'h07;
    push("byp7_za", P_ZA, 32'hA5A5_A5A5);
    push("byp7_zb", P_ZB, 32'hA5A5_A5A5);
    push("nobyp7_za", P_NA, 32'h0000_0007);
    push("nobyp7_zb", P_NB, 32'h0000_0007);
    step();
    we = 1'b0;
    push("after7_za", P_ZA, 32'hA5A5_A5A5);
    push("after7_nb_za", P_NA, 32'hA5A5_A5A5);
    push("after7_nb_zb", P_NB, 32'hA5A5_A5A5);
    step();

    // Reset cycle with a write pending: no forwarding, write discarded.
    reset_n = 1'b0; we = 1'b1; wa = 5'h04; wd = 32'h1234_5678; ra = 5'h04; rb = 5'h07;
    push("rstwr_during_za", P_ZA, 32'h0000_0004);
    push("rstwr_during_zb", P_ZB, 32'hA5A5_A5A5);
    step();
    reset_n = 1'b1; we = 1'b0;
    push("rstwr_after_za", P_ZA, 32'h0);
    push("rstwr_after_zb", P_ZB, 32'h0);
    push("rstwr_after_nb", P_NA, 32'h0);
    step();

    s_we = 1'b1; s_wa = 3'd7; s_wd = 8'hFF;
    step();
    s_wa = 3'd1; s_wd = 8'h01; s_ra = 3'd7; s_rb = 3'd1;
    push("small_za_7", P_SA, 32'h0000_00FF);
    push("small_zb_byp1", P_SB, 32'h0000_0001);
    step();
    s_we = 1'b0;
    push("small_za_7b", P_SA, 32'h0000_00FF);
    push("small_zb_1", P_SB, 32'h0000_0001);
    step();
    s_we = 1'b1; s_wa = 3'd0; s_wd = 8'hAA; s_ra = 3'd0; s_rb = 3'd7;
    push("small_zero_za", P_SA, 32'h0);
    push("small_zb_7", P_SB, 32'h0000_00FF);
    step();
    s_we = 1'b0;
    push("small_zero_after", P_SA, 32'h0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_file_2r1w.md
REG_FILE_2R1W -- requirements
Module: reg_file_2r1w

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL provide parameter DEPTH, default 32, number of registers (power of two, >=2).
REQ-003 SHALL provide parameter ADDR_W, default 5, address width, equal to log2(DEPTH).
REQ-004 SHALL provide parameter ZERO_REG, default 1; when 1, register 0 reads as constant zero.
REQ-005 SHALL provide parameter BYPASS, default 1; when 1, a same-cycle write is forwarded to the read ports.
REQ-006 SHALL use one clock; reset is synchronous and active-low.
REQ-007 clk  input  1  rising-edge clock for all state.
REQ-008 reset_n  input  1  synchronous active-low reset.
REQ-009 we  input  1  write enable, sampled at rising clk.
REQ-010 wa  input  ADDR_W  write address.
REQ-011 wd  input  WIDTH  write data.
REQ-012 ra  input  ADDR_W  read port A address.
REQ-013 rb  input  ADDR_W  read port B address.
REQ-014 za  output  WIDTH  read port A data.
REQ-015 zb  output  WIDTH  read port B data.

Function
REQ-016 SHALL hold DEPTH registers of WIDTH bits each.
REQ-017 SHALL write wd into register wa at rising clk when reset_n=1 and we=1; all other registers hold.
REQ-018 SHALL ignore writes to address 0 when ZERO_REG=1; register 0 stays zero.
REQ-019 SHALL drive za and zb combinationally from the stored register selected by ra and rb, with zero clock latency.
REQ-020 SHALL, when BYPASS=1, we=1, reset_n=1 and ra==wa, drive za=wd in the same cycle (zb likewise for rb==wa).
REQ-021 SHALL NOT bypass when wa==0 and ZERO_REG=1; the read returns zero.
REQ-022 SHALL, when BYPASS=0, return the pre-write stored value in the write cycle and the new value from the next cycle.
REQ-023 SHALL allow ra==rb; both ports then return identical data.
REQ-024 SHALL implement each read port as a DEPTH:1 WIDTH-bit selector generated from the parameters, with no fixed port list.
REQ-025 SHALL have no undefined output for any in-range address; ADDR_W bits cover all DEPTH entries.

Reset
REQ-026 SHALL clear every register to 0 at rising clk while reset_n=0.
REQ-027 SHALL give reset priority over we; a write presented in a reset cycle is discarded.
REQ-028 SHALL suppress bypass while reset_n=0; za and zb reflect stored contents (0 after the first reset edge).
REQ-029 SHALL, when reset asserts between writes, lose all previous contents; the first post-reset read of any address returns 0.

Verification
REQ-030 Reset: reset_n=0 for 2 cycles, then ra=5'h03, rb=5'h1F -> za=32'h0, zb=32'h0.
REQ-031 Write/readback: write i to register i (i=1..31) with wd=32'h0000_0000+i, then sweep ra 0..31 -> za=i for each, za=0 at ra=0.
REQ-032 Zero register: we=1, wa=0, wd=32'hDEAD_BEEF, ra=0 -> za=0 in the write cycle and after.
REQ-033 Bypass: reg 7 holds 32'h7; we=1, wa=7, wd=32'hA5A5_A5A5, ra=rb=7 -> za=zb=32'hA5A5_A5A5 in the same cycle (BYPASS=1); with BYPASS=0, 32'h7 then 32'hA5A5_A5A5 next cycle.
REQ-034 Reset vs write: reset_n=0, we=1, wa=4, wd=32'h1234_5678 -> after the edge, ra=4 gives za=0.
REQ-035 Parameter sweep: WIDTH=8, DEPTH=8, ADDR_W=3; write 8'hFF to reg 7, 8'h01 to reg 1 -> ra=7 gives 8'hFF, rb=1 gives 8'h01.
